inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 24 ++
 rtl/inst_fetch.sv | 90 +++++++++
 tb/tb_inst_fetch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch handshakes: redirect, instruction memory port, decode queue head
interface inst_fetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, mem_ready, mem_resp_valid, mem_resp_data, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ready, mem_resp_valid, mem_resp_data, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetcher with a small in-order instruction queue
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {REQ, WAIT, DRAIN} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   pend_pc;
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after_pop;
  logic          pop;
  logic          push;
  logic          accept;

  // A slot freed by this cycle's pop may already be claimed by a new request.
  assign pop             = bus.inst_valid && bus.inst_ready;
  assign count_after_pop = count - CW'(pop);
  assign bus.mem_req     = !rst && (state == REQ) && (count_after_pop < CW'(QUEUE_DEPTH));
  assign bus.mem_addr    = pc & ~32'd3;
  assign accept          = bus.mem_req && bus.mem_ready;
  assign push            = (state == WAIT) && bus.mem_resp_valid;

  assign bus.inst_valid  = !rst && (count != '0);
  assign bus.inst        = q_inst[head];
  assign bus.inst_pc     = q_pc[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= REQ;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (bus.redirect) begin
      // Anything in flight belongs to the old path; DRAIN swallows its response.
      pc    <= bus.redirect_pc & ~32'd3;
      count <= '0;
      head  <= '0;
      tail  <= '0;
      if (state == REQ)
        state <= accept ? DRAIN : REQ;
      else
        state <= bus.mem_resp_valid ? REQ : DRAIN;
    end else begin
      case (state)
        REQ: begin
          if (accept) begin
            pend_pc <= bus.mem_addr;
            pc      <= pc + 32'd4;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            q_inst[tail] <= bus.mem_resp_data;
            q_pc[tail]   <= pend_pc;
            tail         <= tail + 1'b1;
            state        <= REQ;
          end
        end
        DRAIN: begin
          if (bus.mem_resp_valid)
            state <= REQ;
        end
        default: state <= REQ;
      endcase

      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;

      if (pop)
        head <= head + 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed scoreboard bench for inst_fetch with a budgeted latency memory model
module tb_inst_fetch;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          budget  = 0;
  int          mem_lat = 1;
  int unsigned cyc     = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] pend_addr_q[$];
  int unsigned pend_due_q[$];

  // The memory grants exactly `budget` requests, so expected deliveries are known up front.
  assign bus.mem_ready = (budget != 0);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] inst);
    exp_pc_q.push_back(pc);
    exp_inst_q.push_back(inst);
  endtask

  task automatic wait_drained(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_pc_q.size() == 0) break;
      tick();
    end
    check({"drained_", name}, exp_pc_q.size(), 0);
  endtask

  initial begin : memory
    bit acc;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      acc = (rst === 1'b0) && bus.mem_req && bus.mem_ready;
      if (acc) begin
        pend_addr_q.push_back(bus.mem_addr);
        pend_due_q.push_back(cyc + int'(mem_lat));
      end
      @(posedge clk);
      cyc++;
      #1;
      if (acc) budget--;
      bus.mem_resp_valid = 1'b0;
      if (pend_due_q.size() != 0 && pend_due_q[0] <= cyc) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = mem_word(pend_addr_q.pop_front());
        void'(pend_due_q.pop_front());
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.inst_valid && bus.inst_ready) begin
        if (exp_pc_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_inst: got pc %h inst %h expected no delivery", bus.inst_pc, bus.inst);
        end else begin
          check("deliver_pc", bus.inst_pc, exp_pc_q.pop_front());
          check("deliver_inst", bus.inst, exp_inst_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst             = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0500;
    bus.inst_ready  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_mem_req", bus.mem_req, 0);
      check("reset_inst_valid", bus.inst_valid, 0);
    end

    tick(); rst = 1'b0; bus.redirect = 1'b0;
    @(negedge clk);
    check("first_req", bus.mem_req, 1);
    check("first_addr", bus.mem_addr, RPC);
    check("first_inst_valid", bus.inst_valid, 0);

    // In-order stream and request-to-valid latency
    tick(); bus.inst_ready = 1'b1; budget = 3;
    expect_word(32'h0000_0100, 32'h1000_0100);
    expect_word(32'h0000_0104, 32'h1000_0104);
    expect_word(32'h0000_0108, 32'h1000_0108);
    @(negedge clk); check("lat_accept_valid", bus.inst_valid, 0);
    tick(); @(negedge clk); check("lat_resp_valid", bus.inst_valid, 0);
    tick(); @(negedge clk);
    check("lat_out_valid", bus.inst_valid, 1);
    check("lat_out_pc", bus.inst_pc, 32'h0000_0100);
    wait_drained("stream", 40);
    tick(); @(negedge clk);
    check("stream_next_req", bus.mem_req, 1);
    check("stream_next_addr", bus.mem_addr, 32'h0000_010C);

    // Back-pressure fills the queue, then release
    tick(); bus.inst_ready = 1'b0; budget = 6;
    expect_word(32'h0000_010C, 32'h1000_010C);
    expect_word(32'h0000_0110, 32'h1000_0110);
    expect_word(32'h0000_0114, 32'h1000_0114);
    expect_word(32'h0000_0118, 32'h1000_0118);
    expect_word(32'h0000_011C, 32'h1000_011C);
    expect_word(32'h0000_0120, 32'h1000_0120);
    repeat (14) tick();
    @(negedge clk);
    check("full_mem_req", bus.mem_req, 0);
    check("full_granted", budget, 2);
    check("full_valid", bus.inst_valid, 1);
    check("full_head_pc", bus.inst_pc, 32'h0000_010C);
    tick(); bus.inst_ready = 1'b1;
    wait_drained("release", 60);

    // Redirect in WAIT, response one cycle later is dropped
    tick(); mem_lat = 2; budget = 1;
    @(negedge clk); check("rw_req_addr", bus.mem_addr, 32'h0000_0124);
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0203;
    @(negedge clk); check("rw_wait_req", bus.mem_req, 0);
    tick(); bus.redirect = 1'b0; mem_lat = 1; budget = 1;
    @(negedge clk); check("rw_drain_req", bus.mem_req, 0);
    tick();
    @(negedge clk);
    check("rw_new_req", bus.mem_req, 1);
    check("rw_new_addr", bus.mem_addr, 32'h0000_0200);
    check("rw_empty", bus.inst_valid, 0);
    expect_word(32'h0000_0200, 32'h1000_0200);
    wait_drained("redirect_wait", 20);

    // Redirect coincident with response flushes a held entry
    tick(); bus.inst_ready = 1'b0; budget = 2;
    tick();
    tick();
    @(negedge clk);
    check("rc_held_valid", bus.inst_valid, 1);
    check("rc_held_pc", bus.inst_pc, 32'h0000_0204);
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0300;
    tick(); bus.redirect = 1'b0;
    @(negedge clk);
    check("rc_flush_valid", bus.inst_valid, 0);
    check("rc_req", bus.mem_req, 1);
    check("rc_addr", bus.mem_addr, 32'h0000_0300);

    // Redirect in REQ without acceptance, then address wrap
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); check("rq_old_addr", bus.mem_addr, 32'h0000_0300);
    tick(); bus.redirect = 1'b0; bus.inst_ready = 1'b1; budget = 1;
    @(negedge clk);
    check("wrap_req", bus.mem_req, 1);
    check("wrap_top_addr", bus.mem_addr, 32'hFFFF_FFFC);
    expect_word(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    tick();
    tick();
    @(negedge clk);
    check("wrap_zero_req", bus.mem_req, 1);
    check("wrap_zero_addr", bus.mem_addr, 32'h0000_0000);

    // Redirect in the same cycle a request is accepted
    tick(); budget = 1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0400;
    @(negedge clk); check("ra_addr", bus.mem_addr, 32'h0000_0000);
    tick(); bus.redirect = 1'b0;
    @(negedge clk); check("ra_drain_req", bus.mem_req, 0);
    tick();
    @(negedge clk);
    check("ra_new_req", bus.mem_req, 1);
    check("ra_new_addr", bus.mem_addr, 32'h0000_0400);
    check("ra_empty", bus.inst_valid, 0);

    // Reset while WAIT with two entries held; late response must be ignored
    tick(); bus.inst_ready = 1'b0; mem_lat = 3; budget = 3;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (budget == 0) break;
    end
    check("rs_granted", budget, 0);
    check("rs_held_valid", bus.inst_valid, 1);
    check("rs_held_pc", bus.inst_pc, 32'h0000_0400);
    check("rs_wait_req", bus.mem_req, 0);
    tick(); rst = 1'b1;
    @(negedge clk);
    check("rs_in_reset_valid", bus.inst_valid, 0);
    check("rs_in_reset_req", bus.mem_req, 0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rs_restart_req", bus.mem_req, 1);
    check("rs_restart_addr", bus.mem_addr, RPC);
    check("rs_restart_valid", bus.inst_valid, 0);
    tick();
    @(negedge clk);
    check("rs_late_valid", bus.inst_valid, 0);
    check("rs_late_addr", bus.mem_addr, RPC);
    tick(); mem_lat = 1; budget = 1; bus.inst_ready = 1'b1;
    expect_word(RPC, 32'h1000_0100);
    wait_drained("after_reset", 20);

    repeat (3) tick();
    @(negedge clk);
    check("end_empty", bus.inst_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
